fifo_uart_tx: RTL and testbench

//  Read-side consumer for the 8-bit sync FIFO: pops one byte at a time and transmits it
//  as an asynchronous serial frame (start, data LSB-first, optional parity, stop).

---
 rtl/fifo_uart_pkg.sv | 18 +
 rtl/uart_baud_tick.sv | 33 +++
 rtl/fifo_uart_tx.sv | 120 ++++++++++++
 tb/tb_fifo_uart_tx.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM state codes and
// the frame-length helper.
package fifo_uart_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_LATCH  = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_PARITY = 3'd5;
    localparam logic [2:0] S_STOP   = 3'd6;

    // Clock cycles from the first START cycle through the last STOP cycle.
    function automatic int frame_clks(int clks_per_bit, int data_w, int parity_en);
        return (2 + data_w + parity_en) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and flags the last cycle of each
// bit. A clear forces the count back to zero on the next edge.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a sync FIFO one byte at a time and serialises each byte as
// start / data LSB-first / optional even parity / stop on the tx pin.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8,
    parameter int PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              tx,
    output logic              busy,
    output logic              tx_done,
    output logic [15:0]       byte_cnt
);
    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              tick;
    logic              baud_clr;

    // Every state change restarts the bit period, so START begins at count 0.
    assign baud_clr = (state_d != state_q);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clr_i (baud_clr),
        .tick_o(tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (!fifo_empty) state_d = S_FETCH;
            S_FETCH:  state_d = S_LATCH;
            S_LATCH:  state_d = S_START;
            S_START:  if (tick) state_d = S_DATA;
            S_DATA: begin
                if (tick && (idx_q == LAST_IDX)) begin
                    state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: if (tick) state_d = S_STOP;
            S_STOP:   if (tick) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx         = 1'b1;
        fifo_rd_en = 1'b0;
        busy       = (state_q != S_IDLE);
        tx_done    = 1'b0;
        case (state_q)
            S_FETCH:  fifo_rd_en = 1'b1;
            S_START:  tx = 1'b0;
            S_DATA:   tx = shift_q[0];
            S_PARITY: tx = par_q;
            S_STOP:   tx_done = tick;
            default:  tx = 1'b1;
        endcase
    end

    // Read data is valid during LATCH, one cycle after the FETCH pop.
    always_comb begin
        shift_d = shift_q;
        par_d   = par_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (state_q == S_LATCH) begin
            shift_d = fifo_rd_data;
            par_d   = ^fifo_rd_data;
            idx_d   = '0;
        end else if ((state_q == S_DATA) && tick) begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 1'b1;
        end
        if ((state_q == S_STOP) && tick) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            cnt_q <= '0;
        end else begin
            idx_q <= idx_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    assign byte_cnt = cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (4 clk/bit, 4 clk/bit with parity,
// 16 clk/bit) each fed by its own FIFO model, checked against a frame-timing model.
module tb_fifo_uart_tx;

    function automatic int cpb_of(int k);
        return (k == 2) ? 16 : 4;
    endfunction

    function automatic int pe_of(int k);
        return (k == 1) ? 1 : 0;
    endfunction

    logic        clk;
    logic        rst;
    logic        fifo_empty [3];
    logic        fifo_rd_en [3];
    logic [7:0]  rd_data    [3];
    logic        tx         [3];
    logic        busy       [3];
    logic        tx_done    [3];
    logic [15:0] byte_cnt   [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fifo_uart_tx #(
            .CLKS_PER_BIT(cpb_of(g)),
            .DATA_W      (8),
            .PARITY_EN   (pe_of(g))
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .fifo_empty  (fifo_empty[g]),
            .fifo_rd_en  (fifo_rd_en[g]),
            .fifo_rd_data(rd_data[g]),
            .tx          (tx[g]),
            .busy        (busy[g]),
            .tx_done     (tx_done[g]),
            .byte_cnt    (byte_cnt[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FIFO contents as a circular buffer per instance
    logic [7:0] fbuf [3][256];
    int         whd [3];
    int         rhd [3];
    logic       hide [3];
    logic       noise_en [3];

    // Frame model: m_t counts cycles since the FETCH cycle of the current frame
    logic       m_act [3];
    int         m_t   [3];
    logic [7:0] m_byte [3];
    logic [15:0] m_cnt [3];

    int n_checks;
    int n_err;

    function automatic int fsize(int k);
        return whd[k] - rhd[k];
    endfunction

    task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s[%0d] @%0t: got %0h expected %0h", nm, k, $time, act, exp);
        end
    endtask

    task automatic upd_empty(int k);
        fifo_empty[k] = (fsize(k) == 0) || hide[k];
    endtask

    task automatic push(int k, logic [7:0] b);
        fbuf[k][whd[k] & 255] = b;
        whd[k]++;
        upd_empty(k);
    endtask

    // Compare outputs against the model, then advance the model one cycle.
    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            logic e_tx, e_rd, e_busy, e_done;
            int   len, b;
            len    = (2 + 8 + pe_of(k)) * cpb_of(k);
            e_tx   = 1'b1;
            e_rd   = 1'b0;
            e_busy = 1'b0;
            e_done = 1'b0;
            if (rst) begin
                m_act[k] = 1'b0;
                m_cnt[k] = 16'd0;
            end else if (m_act[k]) begin
                e_busy = 1'b1;
                e_rd   = (m_t[k] == 0);
                if (m_t[k] == 0)
                    m_byte[k] = (fsize(k) > 0) ? fbuf[k][rhd[k] & 255] : 8'h00;
                if (m_t[k] >= 2) begin
                    b = (m_t[k] - 2) / cpb_of(k);
                    if (b == 0)
                        e_tx = 1'b0;
                    else if (b <= 8)
                        e_tx = m_byte[k][b-1];
                    else if ((pe_of(k) != 0) && (b == 9))
                        e_tx = ^m_byte[k];
                end
                e_done = (m_t[k] == len + 1);
            end
            chk("tx", k, 32'(tx[k]), 32'(e_tx));
            chk("rd_en", k, 32'(fifo_rd_en[k]), 32'(e_rd));
            chk("busy", k, 32'(busy[k]), 32'(e_busy));
            chk("tx_done", k, 32'(tx_done[k]), 32'(e_done));
            chk("byte_cnt", k, 32'(byte_cnt[k]), 32'(m_cnt[k]));
            if (!rst) begin
                if (!m_act[k]) begin
                    if (!fifo_empty[k]) begin
                        m_act[k] = 1'b1;
                        m_t[k]   = 0;
                    end
                end else if (m_t[k] == len + 1) begin
                    m_act[k] = 1'b0;
                    m_cnt[k] = m_cnt[k] + 16'd1;
                end else begin
                    m_t[k]++;
                end
            end
        end
    endtask

    // One clock: latch pop requests at negedge, serve them after the posedge.
    // Returns at posedge+1, where stimulus may push and sample outputs.
    task automatic step();
        logic pend [3];
        @(negedge clk);
        for (int k = 0; k < 3; k++) pend[k] = fifo_rd_en[k];
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (pend[k] && (fsize(k) > 0)) begin
                rd_data[k] = fbuf[k][rhd[k] & 255];
                rhd[k]++;
            end else begin
                rd_data[k] = 8'($urandom);
            end
            if (noise_en[k] && ($urandom_range(0, 7) == 0)) hide[k] = ~hide[k];
            upd_empty(k);
        end
    endtask

    task automatic wait_rd(int k, output int n);
        n = 0;
        while (n < 300) begin
            step();
            n++;
            if (fifo_rd_en[k]) return;
        end
        n_checks++;
        n_err++;
        $display("FAIL timeout_rd_en[%0d]: no pop within %0d cycles, required one", k, n);
    endtask

    // Assert rst away from any edge and check outputs clear before the next edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_tx", k, 32'(tx[k]), 32'd1);
            chk("rst_busy", k, 32'(busy[k]), 32'd0);
            chk("rst_rd_en", k, 32'(fifo_rd_en[k]), 32'd0);
            chk("rst_done", k, 32'(tx_done[k]), 32'd0);
            chk("rst_cnt", k, 32'(byte_cnt[k]), 32'd0);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_random();
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                int k;
                k = $urandom_range(0, 2);
                if (fsize(k) < 6) push(k, 8'($urandom));
            end
            if ($urandom_range(0, 1999) == 0) do_reset();
            else step();
        end
    endtask

    initial begin
        int         n;
        int         pops;
        int         extra;
        logic [15:0] c0;
        logic [9:0] frame;

        rst = 1'b1;
        n_checks = 0;
        n_err = 0;
        for (int k = 0; k < 3; k++) begin
            whd[k] = 0; rhd[k] = 0; hide[k] = 1'b0; noise_en[k] = 1'b0;
            m_act[k] = 1'b0; m_t[k] = 0; m_byte[k] = 8'h00; m_cnt[k] = 16'd0;
            rd_data[k] = 8'h00;
            fifo_empty[k] = 1'b1;
        end

        fork
            forever begin
                @(negedge clk);
                compare_all();
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("init_tx", k, 32'(tx[k]), 32'd1);
            chk("init_cnt", k, 32'(byte_cnt[k]), 32'd0);
        end
        rst = 1'b0;
        step();

        // Reset while the start bit drives tx low
        push(0, 8'h42);
        wait_rd(0, n);
        repeat (3) step();
        chk("start_low_pre_rst", 0, 32'(tx[0]), 32'd0);
        do_reset();

        // Single byte 0xA5, pinned by literal frame bits
        push(0, 8'hA5);
        step();
        chk("a5_rd_pulse", 0, 32'(fifo_rd_en[0]), 32'd1);
        step();
        chk("a5_rd_single", 0, 32'(fifo_rd_en[0]), 32'd0);
        step();
        chk("a5_start", 0, 32'(tx[0]), 32'd0);
        frame = 10'b1_10100101_0;
        step();
        for (int b = 0; b < 10; b++) begin
            chk($sformatf("a5_bit%0d", b), 0, 32'(tx[0]), 32'(frame[b]));
            if (b < 9) repeat (4) step();
        end
        repeat (2) step();
        chk("a5_done", 0, 32'(tx_done[0]), 32'd1);
        step();
        chk("a5_done_single", 0, 32'(tx_done[0]), 32'd0);
        chk("a5_cnt", 0, 32'(byte_cnt[0]), 32'd1);

        // Three queued bytes, then a long quiet period
        c0 = byte_cnt[0];
        pops = 0;
        push(0, 8'h00);
        push(0, 8'hFF);
        push(0, 8'h55);
        for (int i = 0; i < 360; i++) begin
            step();
            if (fifo_rd_en[0]) pops++;
        end
        chk("three_pops", 0, 32'(pops), 32'd3);
        chk("three_cnt", 0, 32'(byte_cnt[0]), 32'(c0 + 16'd3));
        chk("three_idle_tx", 0, 32'(tx[0]), 32'd1);

        // Reset during data bit 3 of 0x3C; the next byte must still go out
        push(0, 8'h3C);
        push(0, 8'h81);
        wait_rd(0, n);
        repeat (19) step();
        chk("pre_rst_busy", 0, 32'(busy[0]), 32'd1);
        do_reset();
        wait_rd(0, n);
        repeat (44) step();
        chk("recover_cnt", 0, 32'(byte_cnt[0]), 32'd1);
        chk("recover_fifo", 0, 32'(fsize(0)), 32'd0);

        // Parity instance: 0x07 -> 1, 0x03 -> 0, 44-clk frames, 3-cycle gap
        push(1, 8'h07);
        push(1, 8'h03);
        wait_rd(1, n);
        repeat (39) step();
        chk("parity_07", 1, 32'(tx[1]), 32'd1);
        repeat (6) step();
        chk("parity_done_44", 1, 32'(tx_done[1]), 32'd1);
        wait_rd(1, n);
        chk("parity_gap", 1, 32'(n), 32'd2);
        repeat (39) step();
        chk("parity_03", 1, 32'(tx[1]), 32'd0);

        // 16 clk/bit with a jittering empty flag: bit period and no extra pops
        noise_en[2] = 1'b1;
        push(2, 8'h01);
        push(2, 8'hC3);
        wait_rd(2, n);
        step();
        step();
        n = 0;
        while ((tx[2] == 1'b0) && (n < 100)) begin
            n++;
            step();
        end
        chk("bit_period_16", 2, 32'(n), 32'd16);
        extra = 0;
        for (int i = 0; i < 140; i++) begin
            if (fifo_rd_en[2]) extra++;
            step();
        end
        chk("no_extra_pop", 2, 32'(extra), 32'd0);

        for (int k = 0; k < 3; k++) noise_en[k] = 1'b1;
        run_random();

        for (int k = 0; k < 3; k++) begin
            noise_en[k] = 1'b0;
            hide[k] = 1'b0;
            upd_empty(k);
        end
        repeat (1500) step();
        for (int k = 0; k < 3; k++) begin
            chk("drained", k, 32'(fsize(k)), 32'd0);
            chk("final_idle", k, 32'(busy[k]), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
